led_blink_driver: RTL

//  Output-side counterpart of the button debounce path: turns single-cycle event strobes into

---
 rtl/led_blink_driver_pkg.sv | 14 +
 rtl/led_blink_driver_channel.sv | 128 ++++++++++++
 rtl/led_blink_driver.sv | 76 +++++++
 3 files changed

// File: rtl/led_blink_driver_pkg.sv
// Shared types for the LED blink driver: per-channel blink FSM state encoding.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
//
// Encoding 2'd3 is unused; the channel FSM treats it as illegal and recovers to IDLE.
package led_blink_driver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } blink_state_t;

endpackage

// File: rtl/led_blink_driver_channel.sv
// One LED channel: queues event strobes and replays them as ON/OFF blinks.
// Latency: an evt that arrives while the channel is idle puts the FSM in ON at the same edge.
// Backpressure: none. Events beyond the saturated pending count are dropped and flagged sticky in overflow.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   evt        : single-cycle event strobe
//   ovf_clr    : clears the sticky overflow flag (a simultaneous drop wins)
//   lit_on     : FSM is in ON (PWM gating is applied at the top level)
//   busy       : blink in progress or events pending (decoded from flops only)
//   overflow   : sticky dropped-event flag
module led_blink_driver_channel
   import led_blink_driver_pkg::*;
#(
   parameter int ON_CYCLES  = 6_000_000,
   parameter int OFF_CYCLES = 6_000_000,
   parameter int TIMER_BITS = 23,
   parameter int PEND_BITS  = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic evt,
   input  logic ovf_clr,
   output logic lit_on,
   output logic busy,
   output logic overflow
);

   localparam logic [TIMER_BITS-1:0] ON_LOAD  = TIMER_BITS'(ON_CYCLES - 1);
   localparam logic [TIMER_BITS-1:0] OFF_LOAD = TIMER_BITS'(OFF_CYCLES - 1);
   localparam logic [PEND_BITS-1:0]  PEND_MAX = '1;

   blink_state_t          state, state_nxt;
   logic [TIMER_BITS-1:0] timer, timer_nxt;
   logic [PEND_BITS-1:0]  pend, pend_nxt;
   logic                  ovf_q, ovf_nxt;
   logic                  timer_zero, pend_nz, consume, drop;

   assign timer_zero = (timer == '0);
   assign pend_nz    = (pend != '0);

   // A blink starts either straight from IDLE, or back-to-back at the end
   // of the OFF gap when more events are queued.
   always_comb begin
      consume = 1'b0;
      case (state)
         ST_IDLE: consume = pend_nz | evt;
         ST_OFF:  consume = timer_zero & pend_nz;
         default: consume = 1'b0;
      endcase
   end

   // An event can only be lost when the queue is full and nothing drains it this cycle.
   assign drop = evt & (pend == PEND_MAX) & ~consume;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (consume)    state_nxt = ST_ON;
         ST_ON:   if (timer_zero) state_nxt = ST_OFF;
         ST_OFF:  if (timer_zero) state_nxt = consume ? ST_ON : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output decode (flop-only paths)
   always_comb begin
      lit_on   = (state == ST_ON);
      busy     = (state != ST_IDLE) | pend_nz;
      overflow = ovf_q;
   end

   // Timer, pending counter and sticky overflow
   always_comb begin
      timer_nxt = timer;
      if (consume) begin
         timer_nxt = ON_LOAD;
      end else if ((state == ST_ON) && timer_zero) begin
         timer_nxt = OFF_LOAD;
      end else if ((state == ST_ON) || (state == ST_OFF)) begin
         if (!timer_zero) timer_nxt = timer - TIMER_BITS'(1);
      end else begin
         timer_nxt = '0;
      end
   end

   // consume without evt implies pend != 0, so the decrement cannot underflow.
   always_comb begin
      pend_nxt = pend;
      if (evt && !consume && !drop) begin
         pend_nxt = pend + PEND_BITS'(1);
      end else if (!evt && consume) begin
         pend_nxt = pend - PEND_BITS'(1);
      end
   end

   always_comb begin
      ovf_nxt = ovf_q;
      if (drop) begin
         ovf_nxt = 1'b1;
      end else if (ovf_clr) begin
         ovf_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
         pend  <= '0;
         ovf_q <= 1'b0;
      end else begin
         timer <= timer_nxt;
         pend  <= pend_nxt;
         ovf_q <= ovf_nxt;
      end
   end

endmodule

// File: rtl/led_blink_driver.sv
// N-channel LED blink driver: event strobes become fixed-length blinks with global PWM brightness.
// Latency: evt sampled at edge E0 lights the led pin from E1; pins are registered.
// Backpressure: none. Each channel queues events and flags drops in overflow.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   evt[N]     : per-channel single-cycle event strobes
//   bright     : global brightness, lit while pwm_ctr <= bright
//   ovf_clr    : clears all overflow flags
//   led[N]     : LED pins, polarity per ACTIVE_LOW (dark in reset)
//   busy[N]    : channel blinking or events pending
//   overflow[N]: sticky dropped-event flags
module led_blink_driver #(
   parameter int N          = 8,
   parameter int ON_CYCLES  = 6_000_000,
   parameter int OFF_CYCLES = 6_000_000,
   parameter int TIMER_BITS = 23,
   parameter int PEND_BITS  = 4,
   parameter int PWM_BITS   = 4,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N-1:0]        evt,
   input  logic [PWM_BITS-1:0] bright,
   input  logic                ovf_clr,
   output logic [N-1:0]        led,
   output logic [N-1:0]        busy,
   output logic [N-1:0]        overflow
);

   logic [PWM_BITS-1:0] pwm_ctr;
   logic [N-1:0]        ch_on;
   logic [N-1:0]        lit;
   logic                pwm_pass;

   for (genvar i = 0; i < N; i++) begin : g_ch
      led_blink_driver_channel #(
         .ON_CYCLES  (ON_CYCLES),
         .OFF_CYCLES (OFF_CYCLES),
         .TIMER_BITS (TIMER_BITS),
         .PEND_BITS  (PEND_BITS)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .evt      (evt[i]),
         .ovf_clr  (ovf_clr),
         .lit_on   (ch_on[i]),
         .busy     (busy[i]),
         .overflow (overflow[i])
      );
   end

   // Shared free-running PWM counter; wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_ctr <= '0;
      end else begin
         pwm_ctr <= pwm_ctr + PWM_BITS'(1);
      end
   end

   // bright = all-ones gives full duty; bright = 0 lights only on pwm_ctr == 0.
   assign pwm_pass = (pwm_ctr <= bright);
   assign lit      = ch_on & {N{pwm_pass}};

   // Registered pins keep the board outputs glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= {N{ACTIVE_LOW}};
      end else begin
         led <= lit ^ {N{ACTIVE_LOW}};
      end
   end

endmodule
